// File: rtl/updown_acc_pkg.sv
// Shared mode constants and range-limit helpers for the up/down accumulator.
package updown_acc_pkg;

   localparam int SAT_WRAP  = 0;
   localparam int SAT_CLAMP = 1;
   localparam int UNSIGNED  = 0;
   localparam int SIGNED    = 1;

   // Widest accumulator the helpers can describe; callers slice down to WIDTH.
   localparam int MAX_W = 64;

   function automatic logic [MAX_W-1:0] maxValue(input int width, input int signedMode);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      if (signedMode == SIGNED) v[width-1] = 1'b0;
      return v;
   endfunction

   function automatic logic [MAX_W-1:0] minValue(input int width, input int signedMode);
      logic [MAX_W-1:0] v;
      v = '0;
      if (signedMode == SIGNED) v[width-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/updown_acc_addsub.sv
// Ripple-carry add/subtract built from full_adder cells; subtract inverts b
// and injects a carry of one.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module addsub_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_m,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH:0]   w_carry;

   assign w_bx       = i_b ^ {WIDTH{~i_m}};
   assign w_carry[0] = ~i_m;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      full_adder u_fa (
         .i_a    (i_a[g]),
         .i_b    (w_bx[g]),
         .i_cin  (w_carry[g]),
         .o_sum  (o_sum[g]),
         .o_cout (w_carry[g+1])
      );
   end

   assign o_cout = w_carry[WIDTH];
   // Overflow: both effective operands share a sign that the sum does not.
   assign o_ovf  = (i_a[WIDTH-1] == w_bx[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/updown_acc.sv
// Registered WIDTH-bit accumulator stepped by add/subtract/load, with optional
// saturation and valid/ready handshakes on input and output.
module updown_acc #(
   parameter int WIDTH  = 8,
   parameter int SAT    = 0,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ld,
   input  logic             m,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] acc,
   output logic             cout,
   output logic             ovf,
   output logic             sat,
   output logic             out_valid,
   input  logic             out_ready
);

   import updown_acc_pkg::*;

   localparam int                 SIGNED_MODE = (SIGNED == updown_acc_pkg::SIGNED) ? 1 : 0;
   localparam logic [MAX_W-1:0]   MAX_FULL    = maxValue(WIDTH, SIGNED_MODE);
   localparam logic [MAX_W-1:0]   MIN_FULL    = minValue(WIDTH, SIGNED_MODE);
   localparam logic [WIDTH-1:0]   MAX_VAL     = MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]   MIN_VAL     = MIN_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] r_acc;
   logic             r_cout;
   logic             r_ovf;
   logic             r_sat;
   logic             r_outValid;

   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;
   logic [WIDTH-1:0] w_resAcc;
   logic             w_resSat;
   logic             w_accept;

   addsub_w #(.WIDTH(WIDTH)) u_addsub (
      .i_a    (r_acc),
      .i_b    (din),
      .i_m    (m),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   assign in_ready = !r_outValid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Clamp selection: unsigned limits follow the carry, signed limits follow ovf.
   always_comb begin
      w_resAcc = w_sum;
      w_resSat = 1'b0;
      if (SAT == SAT_CLAMP) begin
         if (SIGNED_MODE == 1) begin
            if (w_ovf) begin
               w_resAcc = r_acc[WIDTH-1] ? MIN_VAL : MAX_VAL;
               w_resSat = 1'b1;
            end
         end else begin
            if (m && w_cout) begin
               w_resAcc = MAX_VAL;
               w_resSat = 1'b1;
            end else if (!m && !w_cout) begin
               w_resAcc = MIN_VAL;
               w_resSat = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_sat      <= 1'b0;
         r_outValid <= 1'b0;
      end else if (w_accept) begin
         if (ld) begin
            r_acc  <= din;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_sat  <= 1'b0;
         end else begin
            r_acc  <= w_resAcc;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_sat  <= w_resSat;
         end
         r_outValid <= 1'b1;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign acc       = r_acc;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign sat       = r_sat;
   assign out_valid = r_outValid;

endmodule

// File: tb/tb_updown_acc.sv
// Drives wrap, unsigned-saturate and signed-saturate 4-bit accumulators with
// shared stimulus and scoreboards each against an integer reference model.
module tb_updown_acc;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] acc;
      logic         cout;
      logic         ovf;
      logic         sat;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         ld;
   logic         m;
   logic [W-1:0] din;
   logic         out_ready;

   logic         inReady  [3];
   logic [W-1:0] accOut   [3];
   logic         coutOut  [3];
   logic         ovfOut   [3];
   logic         satOut   [3];
   logic         outValid [3];

   int   total = 0;
   int   bad   = 0;

   res_t modelState [3];
   bit   modelPending;
   res_t expQ [3][$];

   always #5 clk = ~clk;

   updown_acc #(.WIDTH(W), .SAT(0), .SIGNED(0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[0]),
      .ld(ld), .m(m), .din(din), .acc(accOut[0]), .cout(coutOut[0]),
      .ovf(ovfOut[0]), .sat(satOut[0]), .out_valid(outValid[0]), .out_ready(out_ready)
   );

   updown_acc #(.WIDTH(W), .SAT(1), .SIGNED(0)) u_usat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[1]),
      .ld(ld), .m(m), .din(din), .acc(accOut[1]), .cout(coutOut[1]),
      .ovf(ovfOut[1]), .sat(satOut[1]), .out_valid(outValid[1]), .out_ready(out_ready)
   );

   updown_acc #(.WIDTH(W), .SAT(1), .SIGNED(1)) u_ssat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[2]),
      .ld(ld), .m(m), .din(din), .acc(accOut[2]), .cout(coutOut[2]),
      .ovf(ovfOut[2]), .sat(satOut[2]), .out_valid(outValid[2]), .out_ready(out_ready)
   );

   // Reference step computed with plain integer arithmetic on the operand values.
   function automatic res_t refStep(res_t cur, bit doLd, bit doAdd, logic [W-1:0] d,
                                    bit satOn, bit sgn);
      res_t r;
      int   ua, ub, sa, sb, raw, sr;
      ua = int'(cur.acc);
      ub = int'(d);
      sa = (ua >= 8) ? ua - 16 : ua;
      sb = (ub >= 8) ? ub - 16 : ub;
      r.sat = 1'b0;
      if (doLd) begin
         r.acc  = d;
         r.cout = 1'b0;
         r.ovf  = 1'b0;
         return r;
      end
      if (doAdd) begin
         raw    = ua + ub;
         r.cout = (raw >= 16);
         sr     = sa + sb;
      end else begin
         raw    = ua - ub;
         r.cout = (ua >= ub);
         sr     = sa - sb;
      end
      r.ovf = (sr > 7) || (sr < -8);
      r.acc = 4'((raw + 16) % 16);
      if (satOn && !sgn) begin
         if (doAdd && r.cout) begin
            r.acc = 4'd15;
            r.sat = 1'b1;
         end else if (!doAdd && !r.cout) begin
            r.acc = 4'd0;
            r.sat = 1'b1;
         end
      end
      if (satOn && sgn && r.ovf) begin
         r.acc = (sa < 0) ? 4'd8 : 4'd7;
         r.sat = 1'b1;
      end
      return r;
   endfunction

   task automatic checkOutput(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s dut%0d actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // One cycle: drive at posedge+1, check handshake/state at negedge, advance model at posedge.
   task automatic applyStimulus(bit r, bit iv, bit l, bit mm, logic [W-1:0] d, bit ordy);
      bit modelReady;
      rst       = r;
      in_valid  = iv;
      ld        = l;
      m         = mm;
      din       = d;
      out_ready = ordy;
      @(negedge clk);
      modelReady = !modelPending || ordy;
      for (int i = 0; i < 3; i++) begin
         checkOutput("in_ready",  i, 32'(inReady[i]),  32'(modelReady));
         checkOutput("out_valid", i, 32'(outValid[i]), 32'(modelPending));
         checkOutput("acc_state", i, 32'(accOut[i]),   32'(modelState[i].acc));
         checkOutput("flags",     i, {29'd0, coutOut[i], ovfOut[i], satOut[i]},
                     {29'd0, modelState[i].cout, modelState[i].ovf, modelState[i].sat});
      end
      @(posedge clk);
      if (r) begin
         modelPending = 1'b0;
         for (int i = 0; i < 3; i++) begin
            modelState[i] = '{acc: '0, cout: 1'b0, ovf: 1'b0, sat: 1'b0};
            expQ[i].delete();
         end
      end else if (iv && modelReady) begin
         for (int i = 0; i < 3; i++) begin
            modelState[i] = refStep(modelState[i], l, mm, d, i != 0, i == 2);
            expQ[i].push_back(modelState[i]);
         end
         modelPending = 1'b1;
      end else if (ordy) begin
         modelPending = 1'b0;
      end
      #1;
   endtask

   // Monitor: every presented result must match the queued expectation; pop when consumed.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (outValid[i] === 1'b1) begin
            if (expQ[i].size() == 0) begin
               checkOutput("unexpected_result", i, 32'd1, 32'd0);
            end else begin
               checkOutput("sb_acc",  i, 32'(accOut[i]),  32'(expQ[i][0].acc));
               checkOutput("sb_cout", i, 32'(coutOut[i]), 32'(expQ[i][0].cout));
               checkOutput("sb_ovf",  i, 32'(ovfOut[i]),  32'(expQ[i][0].ovf));
               checkOutput("sb_sat",  i, 32'(satOut[i]),  32'(expQ[i][0].sat));
               if (out_ready && !rst) void'(expQ[i].pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelPending = 1'b0;
      for (int i = 0; i < 3; i++) modelState[i] = '{acc: '0, cout: 1'b0, ovf: 1'b0, sat: 1'b0};
      rst = 1'b1; in_valid = 1'b1; ld = 1'b0; m = 1'b1; din = 4'h5; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Directed: wrap sequence.
      applyStimulus(0, 1, 1, 0, 4'hE, 1);
      applyStimulus(0, 1, 0, 1, 4'h3, 1);
      applyStimulus(0, 1, 0, 0, 4'h2, 1);
      // Unsigned saturate sequence.
      applyStimulus(0, 1, 1, 0, 4'hE, 1);
      applyStimulus(0, 1, 0, 1, 4'h3, 1);
      applyStimulus(0, 1, 1, 0, 4'h2, 1);
      applyStimulus(0, 1, 0, 0, 4'h5, 1);
      applyStimulus(0, 1, 0, 1, 4'h1, 1);
      // Signed saturate sequence.
      applyStimulus(0, 1, 1, 0, 4'h7, 1);
      applyStimulus(0, 1, 0, 1, 4'h1, 1);
      applyStimulus(0, 1, 1, 0, 4'h8, 1);
      applyStimulus(0, 1, 0, 0, 4'h1, 1);
      applyStimulus(0, 1, 1, 0, 4'h8, 1);
      applyStimulus(0, 1, 0, 1, 4'hF, 1);
      // Backpressure: stall three cycles, then release with an accept in the same cycle.
      applyStimulus(0, 1, 1, 0, 4'h5, 1);
      repeat (3) applyStimulus(0, 1, 0, 1, 4'h1, 0);
      applyStimulus(0, 1, 0, 1, 4'h1, 1);
      applyStimulus(0, 0, 0, 1, 4'h1, 1);
      applyStimulus(0, 0, 0, 1, 4'h1, 1);
      // Reset while a stalled result is pending.
      applyStimulus(0, 1, 1, 0, 4'h3, 1);
      applyStimulus(0, 1, 0, 1, 4'h2, 0);
      applyStimulus(1, 1, 0, 1, 4'h2, 0);
      applyStimulus(0, 0, 0, 1, 4'h2, 1);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
                       1'($urandom % 2), 4'($urandom % 16), ($urandom % 3) != 0);
      end
      applyStimulus(0, 0, 0, 0, 4'h0, 1);
      applyStimulus(0, 0, 0, 0, 4'h0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
